hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised pipeline hazard unit for the in-order core, sitting beside the IF/ID/EX/LS/WB stage registers. It tracks in-flight register writers with a per-register pending-write scoreboard and generates stage enables, flushes and WB-stage bypass selects for NSRC source operands. It also stalls on an outstanding memory access, serialises the pipe on request (fence/CSR drain) and counts stall cycles. Flushes on a resolved jump cancel the killed writer's scoreboard entry.

## Interface
- NSRC, 2, number of source operands checked per instruction
- AW, 5, register address width; registers 1..2^AW-1 tracked, x0 never
- MAX_PEND, 3, max outstanding writers per register; CW = clog2(MAX_PEND+1)
- BYPASS_EN, 1, 1: same-cycle WB data may bypass to ID; 0: wait until the write has retired

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  IF/ID holds a valid instruction
- id_rs_addr  in  NSRC*AW  source addresses, operand i at [i*AW +: AW]
- id_rs_used  in  NSRC  operand i is read
- id_rd_addr  in  AW  destination
- id_rd_wen  in  1  instruction writes rd
- ls_mem_busy  in  1  EX/LS holds a valid load/store
- ls_done  in  1  memory response this cycle
- wb_valid, wb_wen  in  1 each  retiring instruction writes wb_rd this cycle
- wb_rd  in  AW  retiring destination
- redirect_valid  in  1  jump resolved in EX/LS this cycle
- kill_valid, kill_wen  in  1 each  ID/EX occupant being flushed writes kill_rd
- kill_rd  in  AW  flushed destination
- drain_req  in  1  level; request pipe drain
- id_issue  out  1  ID->EX transfer fires
- if_enable, id_enable, ex_enable, ls_enable  out  1 each  stage register enables
- if_flush, id_flush  out  1 each  flush stage registers
- src_bypass  out  NSRC  operand i takes WB data
- id_src_block  out  1  RAW stall this cycle
- drain_done  out  1  one-cycle pulse, pipe empty
- stall_cycles  out  32  saturating count of cycles with id_valid & ~id_issue

## Operation
- Scoreboard: cnt[r] (CW bits) per register r≠0. inc = id_issue & id_rd_wen & rd≠0; dec_wb = wb_valid & wb_wen & wb_rd≠0; dec_kill = kill_valid & kill_wen & kill_rd≠0. Net update of all three applied on the same edge; same register hit twice → sum (e.g. +1−1−1). Underflow is a protocol error (assertion), value unchanged.
- Hazard per used operand i (rs≠0): eff = cnt[rs] − (dec_wb & wb_rd==rs). BYPASS_EN=1: block if eff≠0; src_bypass[i] = used & dec_wb & wb_rd==rs & eff==0. BYPASS_EN=0: block if cnt[rs]≠0; src_bypass all zero.
- Overflow: id_rd_wen with cnt[rd]==MAX_PEND → block.
- ex_enable = ~(ls_mem_busy & ~ls_done); ls_enable = 1.
- id_issue = id_valid & ~id_src_block & ex_enable & ~redirect_valid & state==RUN.
- id_enable = id_issue | (~id_valid & state==RUN); if_enable = id_enable | ~id_valid.
- if_flush = id_flush = redirect_valid; redirect beats issue; the flushed ID-stage instruction never incremented.
- FSM RUN/DRAIN/DONE: RUN→DRAIN on drain_req; in DRAIN no issue; DRAIN→DONE when all cnt==0 and ~ls_mem_busy; DONE pulses drain_done, →RUN. redirect_valid in DRAIN stays in DRAIN.
- stall_cycles saturates at 0xFFFF_FFFF.

## Timing
- Reset: all cnt=0, state=RUN, stall_cycles=0, drain_done=0; combinational outputs follow inputs (with id_valid=0: if/id_enable=1, flushes 0).
- All enables, flushes, bypass, block: combinational from current cnt/state and same-cycle inputs; cnt/state/stall_cycles update on rising clk.
- Dependent instruction issued directly after its producer stalls until the producer's WB cycle (BYPASS_EN=1, bypass then) or one cycle later (BYPASS_EN=0).
- drain_done asserted the cycle after the empty condition is seen; minimum drain latency 2 cycles.
- Reset mid-drain or mid-memory wait: state and counters clear immediately.

## Structure
- Shared package: FSM state enum (RUN, DRAIN, DONE), default NSRC/AW/MAX_PEND constants.
- One sub-module natural: scoreboard_cnt (one register's counter with inc/dec_wb/dec_kill/full/nonzero), generated per register.

## Test plan
- Issue x5 writer, next cycle reader of x5 (BYPASS_EN=1) -> id_src_block=1 until wb of x5, then src_bypass[0]=1, id_issue=1 same cycle.
- Same with BYPASS_EN=0 -> issue one cycle after wb, src_bypass=0.
- Three writers of x7 in flight, fourth writer at ID (MAX_PEND=3) -> blocked until first x7 retires.
- redirect_valid with kill_wen, kill_rd=x9 and wb retiring x9 same cycle, cnt[x9]=2 -> cnt[x9]=0, if_flush=id_flush=1, id_issue=0.
- ls_mem_busy for 4 cycles then ls_done -> ex_enable low 4 cycles, stall_cycles +4 with id_valid held.
- drain_req with 2 writers pending -> no issue, drain_done one pulse the cycle after last wb; assert rst mid-drain -> state RUN, all cnt 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and default sizing for the pipeline hazard scoreboard.
package hazard_scoreboard_pkg;
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } hz_state_e;

    localparam int DEF_NSRC     = 2;
    localparam int DEF_AW       = 5;
    localparam int DEF_MAX_PEND = 3;
endpackage

// File: rtl/hazard_scoreboard_scoreboard_cnt.sv
// Pending-writer counter for one architectural register.
module scoreboard_cnt
    import hazard_scoreboard_pkg::*;
#(
    parameter int MAX_PEND = DEF_MAX_PEND,
    parameter int CW       = $clog2(MAX_PEND + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_wb_i,
    input  logic          dec_kill_i,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          nonzero_o
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   up;
    logic [1:0]    down;

    // Retire and kill may both hit the same entry while a new writer issues.
    always_comb begin
        up    = {1'b0, cnt_q} + (CW+1)'(inc_i);
        down  = {1'b0, dec_wb_i} + {1'b0, dec_kill_i};
        cnt_d = cnt_q;
        if (up >= (CW+1)'(down)) cnt_d = CW'(up - (CW+1)'(down));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) up >= (CW+1)'(down));

    assign cnt_o     = cnt_q;
    assign full_o    = (cnt_q == CW'(MAX_PEND));
    assign nonzero_o = |cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard unit: RAW/overflow stalls, WB bypass, memory stall, drain FSM.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSRC      = DEF_NSRC,
    parameter int AW        = DEF_AW,
    parameter int MAX_PEND  = DEF_MAX_PEND,
    parameter int BYPASS_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid_i,
    input  logic [NSRC*AW-1:0] id_rs_addr_i,
    input  logic [NSRC-1:0]    id_rs_used_i,
    input  logic [AW-1:0]      id_rd_addr_i,
    input  logic               id_rd_wen_i,
    input  logic               ls_mem_busy_i,
    input  logic               ls_done_i,
    input  logic               wb_valid_i,
    input  logic               wb_wen_i,
    input  logic [AW-1:0]      wb_rd_i,
    input  logic               redirect_valid_i,
    input  logic               kill_valid_i,
    input  logic               kill_wen_i,
    input  logic [AW-1:0]      kill_rd_i,
    input  logic               drain_req_i,
    output logic               id_issue_o,
    output logic               if_enable_o,
    output logic               id_enable_o,
    output logic               ex_enable_o,
    output logic               ls_enable_o,
    output logic               if_flush_o,
    output logic               id_flush_o,
    output logic [NSRC-1:0]    src_bypass_o,
    output logic               id_src_block_o,
    output logic               drain_done_o,
    output logic [31:0]        stall_cycles_o
);
    localparam int CW   = $clog2(MAX_PEND + 1);
    localparam int NREG = 1 << AW;

    logic [NREG-1:0][CW-1:0] cnt;
    logic [NREG-1:0]         nz, full;
    logic                    inc, dec_wb, dec_kill, run;
    hz_state_e               state_q, state_d;
    logic [31:0]             stall_q, stall_d;

    assign inc      = id_issue_o && id_rd_wen_i && (id_rd_addr_i != '0);
    assign dec_wb   = wb_valid_i && wb_wen_i && (wb_rd_i != '0);
    assign dec_kill = kill_valid_i && kill_wen_i && (kill_rd_i != '0);

    // x0 is hardwired zero and never tracked.
    assign cnt[0]  = '0;
    assign nz[0]   = 1'b0;
    assign full[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        scoreboard_cnt #(.MAX_PEND(MAX_PEND), .CW(CW)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc_i     (inc && (id_rd_addr_i == AW'(r))),
            .dec_wb_i  (dec_wb && (wb_rd_i == AW'(r))),
            .dec_kill_i(dec_kill && (kill_rd_i == AW'(r))),
            .cnt_o     (cnt[r]),
            .full_o    (full[r]),
            .nonzero_o (nz[r])
        );
    end

    always_comb begin
        id_src_block_o = 1'b0;
        src_bypass_o   = '0;
        for (int i = 0; i < NSRC; i++) begin
            logic [AW-1:0] rs;
            logic          wb_hit;
            logic [CW-1:0] eff;
            rs     = id_rs_addr_i[i*AW +: AW];
            wb_hit = dec_wb && (wb_rd_i == rs);
            eff    = cnt[rs] - CW'(wb_hit);
            if (id_rs_used_i[i] && (rs != '0)) begin
                if (BYPASS_EN != 0) begin
                    if (eff != '0)  id_src_block_o  = 1'b1;
                    else if (wb_hit) src_bypass_o[i] = 1'b1;
                end else if (cnt[rs] != '0) begin
                    id_src_block_o = 1'b1;
                end
            end
        end
        // A fourth in-flight writer would overflow the counter.
        if (id_rd_wen_i && (id_rd_addr_i != '0) && full[id_rd_addr_i]) id_src_block_o = 1'b1;
    end

    assign run         = (state_q == ST_RUN);
    assign ex_enable_o = ~(ls_mem_busy_i & ~ls_done_i);
    assign ls_enable_o = 1'b1;
    assign id_issue_o  = id_valid_i & ~id_src_block_o & ex_enable_o & ~redirect_valid_i & run;
    assign id_enable_o = id_issue_o | (~id_valid_i & run);
    assign if_enable_o = id_enable_o | ~id_valid_i;
    assign if_flush_o  = redirect_valid_i;
    assign id_flush_o  = redirect_valid_i;
    assign drain_done_o = (state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (drain_req_i) state_d = ST_DRAIN;
            ST_DRAIN: if (~|nz && !ls_mem_busy_i) state_d = ST_DONE;
            ST_DONE:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (id_valid_i && !id_issue_o && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles_o = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: one DUT per bypass mode on shared stimulus, directed scenarios plus a randomized model run.
module tb_hazard_scoreboard;
    localparam int AW = 5, NSRC = 2, MAXP = 3;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic id_valid, id_rd_wen, ls_mem_busy, ls_done, wb_valid, wb_wen;
    logic redirect_valid, kill_valid, kill_wen, drain_req;
    logic [NSRC*AW-1:0] id_rs_addr;
    logic [NSRC-1:0]    id_rs_used;
    logic [AW-1:0]      id_rd_addr, wb_rd, kill_rd;

    // index 0: BYPASS_EN=0, index 1: BYPASS_EN=1
    logic o_issue[2], o_ifen[2], o_iden[2], o_exen[2], o_lsen[2];
    logic o_iff[2], o_idf[2], o_blk[2], o_done[2];
    logic [NSRC-1:0] o_byp[2];
    logic [31:0]     o_stall[2];

    int checks = 0, errors = 0;

    hazard_scoreboard #(.NSRC(NSRC), .AW(AW), .MAX_PEND(MAXP), .BYPASS_EN(0)) u_dut0 (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr),
        .id_rs_used_i(id_rs_used), .id_rd_addr_i(id_rd_addr), .id_rd_wen_i(id_rd_wen),
        .ls_mem_busy_i(ls_mem_busy), .ls_done_i(ls_done), .wb_valid_i(wb_valid),
        .wb_wen_i(wb_wen), .wb_rd_i(wb_rd), .redirect_valid_i(redirect_valid),
        .kill_valid_i(kill_valid), .kill_wen_i(kill_wen), .kill_rd_i(kill_rd),
        .drain_req_i(drain_req), .id_issue_o(o_issue[0]), .if_enable_o(o_ifen[0]),
        .id_enable_o(o_iden[0]), .ex_enable_o(o_exen[0]), .ls_enable_o(o_lsen[0]),
        .if_flush_o(o_iff[0]), .id_flush_o(o_idf[0]), .src_bypass_o(o_byp[0]),
        .id_src_block_o(o_blk[0]), .drain_done_o(o_done[0]), .stall_cycles_o(o_stall[0]));

    hazard_scoreboard #(.NSRC(NSRC), .AW(AW), .MAX_PEND(MAXP), .BYPASS_EN(1)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_rs_addr_i(id_rs_addr),
        .id_rs_used_i(id_rs_used), .id_rd_addr_i(id_rd_addr), .id_rd_wen_i(id_rd_wen),
        .ls_mem_busy_i(ls_mem_busy), .ls_done_i(ls_done), .wb_valid_i(wb_valid),
        .wb_wen_i(wb_wen), .wb_rd_i(wb_rd), .redirect_valid_i(redirect_valid),
        .kill_valid_i(kill_valid), .kill_wen_i(kill_wen), .kill_rd_i(kill_rd),
        .drain_req_i(drain_req), .id_issue_o(o_issue[1]), .if_enable_o(o_ifen[1]),
        .id_enable_o(o_iden[1]), .ex_enable_o(o_exen[1]), .ls_enable_o(o_lsen[1]),
        .if_flush_o(o_iff[1]), .id_flush_o(o_idf[1]), .src_bypass_o(o_byp[1]),
        .id_src_block_o(o_blk[1]), .drain_done_o(o_done[1]), .stall_cycles_o(o_stall[1]));

    task automatic idle();
        id_valid = 0; id_rs_addr = '0; id_rs_used = '0; id_rd_addr = '0; id_rd_wen = 0;
        ls_mem_busy = 0; ls_done = 0; wb_valid = 0; wb_wen = 0; wb_rd = '0;
        redirect_valid = 0; kill_valid = 0; kill_wen = 0; kill_rd = '0; drain_req = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst = 1; nxt(); rst = 0; #1;
    endtask

    task automatic instr(input logic v, input int rs0, input logic u0, input int rd, input logic wen);
        id_valid = v; id_rs_addr = '0; id_rs_addr[AW-1:0] = AW'(rs0); id_rs_used = {1'b0, u0};
        id_rd_addr = AW'(rd); id_rd_wen = wen;
    endtask

    task automatic retire(input int rd);
        wb_valid = (rd != 0); wb_wen = (rd != 0); wb_rd = AW'(rd);
    endtask

    task automatic test_reset();
        idle(); rst = 1; #2;
        for (int d = 0; d < 2; d++) begin
            checks++; if (o_stall[d] !== 32'd0) begin errors++; $display("FAIL reset_stall d%0d got %0d exp 0", d, o_stall[d]); end
            checks++; if (o_done[d] !== 1'b0) begin errors++; $display("FAIL reset_done d%0d got %b exp 0", d, o_done[d]); end
            checks++; if ({o_ifen[d], o_iden[d], o_exen[d], o_lsen[d]} !== 4'b1111)
                begin errors++; $display("FAIL reset_enables d%0d got %b exp 1111", d, {o_ifen[d], o_iden[d], o_exen[d], o_lsen[d]}); end
            checks++; if ({o_iff[d], o_idf[d], o_issue[d], o_blk[d], o_byp[d]} !== 6'b0)
                begin errors++; $display("FAIL reset_quiet d%0d got %b exp 000000", d, {o_iff[d], o_idf[d], o_issue[d], o_blk[d], o_byp[d]}); end
        end
        rst = 0; nxt();
    endtask

    task automatic test_raw_bypass();
        do_reset();
        instr(1, 0, 0, 5, 1); #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if (o_issue[d] !== 1'b1) begin errors++; $display("FAIL raw_producer_issue d%0d got %b exp 1", d, o_issue[d]); end
        end
        nxt();
        instr(1, 5, 1, 0, 0);
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                checks++; if ({o_blk[d], o_issue[d]} !== 2'b10) begin errors++; $display("FAIL raw_stall c%0d d%0d got %b exp 10", c, d, {o_blk[d], o_issue[d]}); end
            end
            nxt();
        end
        retire(5); #1;
        checks++; if ({o_blk[1], o_issue[1], o_byp[1]} !== 4'b0101) begin errors++; $display("FAIL raw_wb_bypass got %b exp 0101", {o_blk[1], o_issue[1], o_byp[1]}); end
        checks++; if ({o_blk[0], o_issue[0], o_byp[0]} !== 4'b1000) begin errors++; $display("FAIL raw_wb_nobypass got %b exp 1000", {o_blk[0], o_issue[0], o_byp[0]}); end
        nxt();
        retire(0); #1;
        checks++; if ({o_blk[0], o_issue[0], o_byp[0]} !== 4'b0100) begin errors++; $display("FAIL raw_after_wb_nobypass got %b exp 0100", {o_blk[0], o_issue[0], o_byp[0]}); end
        checks++; if (o_stall[1] !== 32'd2) begin errors++; $display("FAIL raw_stall_cnt_byp got %0d exp 2", o_stall[1]); end
        checks++; if (o_stall[0] !== 32'd3) begin errors++; $display("FAIL raw_stall_cnt_nobyp got %0d exp 3", o_stall[0]); end
        nxt();
    endtask

    task automatic test_overflow();
        do_reset();
        instr(1, 0, 0, 7, 1);
        for (int c = 0; c < 3; c++) begin
            #1; checks++; if (o_issue[1] !== 1'b1) begin errors++; $display("FAIL ovf_fill c%0d got %b exp 1", c, o_issue[1]); end
            nxt();
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if ({o_blk[d], o_issue[d]} !== 2'b10) begin errors++; $display("FAIL ovf_block d%0d got %b exp 10", d, {o_blk[d], o_issue[d]}); end
        end
        nxt();
        retire(7); #1;
        checks++; if (o_blk[1] !== 1'b1) begin errors++; $display("FAIL ovf_block_at_wb got %b exp 1", o_blk[1]); end
        nxt();
        retire(0); #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if ({o_blk[d], o_issue[d]} !== 2'b01) begin errors++; $display("FAIL ovf_release d%0d got %b exp 01", d, {o_blk[d], o_issue[d]}); end
        end
        nxt();
    endtask

    task automatic test_kill();
        do_reset();
        instr(1, 0, 0, 9, 1); nxt(); nxt();
        retire(9); redirect_valid = 1; kill_valid = 1; kill_wen = 1; kill_rd = AW'(9); #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if ({o_iff[d], o_idf[d], o_issue[d], o_iden[d]} !== 4'b1100)
                begin errors++; $display("FAIL kill_flush d%0d got %b exp 1100", d, {o_iff[d], o_idf[d], o_issue[d], o_iden[d]}); end
        end
        nxt();
        idle(); instr(1, 9, 1, 0, 0); #1;
        for (int d = 0; d < 2; d++) begin
            checks++; if ({o_blk[d], o_issue[d]} !== 2'b01) begin errors++; $display("FAIL kill_cleared d%0d got %b exp 01", d, {o_blk[d], o_issue[d]}); end
        end
        nxt();
    endtask

    task automatic test_mem_wait();
        do_reset();
        instr(1, 0, 0, 0, 0); ls_mem_busy = 1;
        for (int c = 0; c < 4; c++) begin
            #1; checks++; if ({o_exen[1], o_issue[1], o_lsen[1]} !== 3'b001) begin errors++; $display("FAIL mem_wait c%0d got %b exp 001", c, {o_exen[1], o_issue[1], o_lsen[1]}); end
            nxt();
        end
        ls_done = 1; #1;
        checks++; if ({o_exen[1], o_issue[1]} !== 2'b11) begin errors++; $display("FAIL mem_done got %b exp 11", {o_exen[1], o_issue[1]}); end
        checks++; if (o_stall[1] !== 32'd4) begin errors++; $display("FAIL mem_stall_cnt got %0d exp 4", o_stall[1]); end
        nxt();
    endtask

    task automatic test_drain();
        logic [2:0] exp_done [9];
        exp_done = '{3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b0, 3'b1, 3'b0, 3'b0};
        do_reset();
        instr(1, 0, 0, 3, 1); nxt();
        instr(1, 0, 0, 4, 1); nxt();
        instr(0, 0, 0, 0, 0); drain_req = 1; #1;
        checks++; if ({o_issue[1], o_iden[1]} !== 2'b01) begin errors++; $display("FAIL drain_req_cycle got %b exp 01", {o_issue[1], o_iden[1]}); end
        nxt();
        drain_req = 0; instr(1, 0, 0, 0, 0);
        for (int c = 3; c < 8; c++) begin
            retire(c == 3 ? 3 : (c == 4 ? 4 : 0)); #1;
            checks++; if (o_done[1] !== exp_done[c][0]) begin errors++; $display("FAIL drain_done c%0d got %b exp %b", c, o_done[1], exp_done[c][0]); end
            checks++; if (o_issue[1] !== (c == 7)) begin errors++; $display("FAIL drain_issue c%0d got %b exp %b", c, o_issue[1], c == 7); end
            nxt();
        end
        checks++; if (o_stall[1] !== 32'd4) begin errors++; $display("FAIL drain_stall_cnt got %0d exp 4", o_stall[1]); end
        instr(1, 0, 0, 3, 1); nxt();
        instr(0, 0, 0, 0, 0); drain_req = 1; nxt();
        drain_req = 0; instr(1, 3, 1, 0, 0); #1;
        checks++; if ({o_blk[1], o_issue[1]} !== 2'b10) begin errors++; $display("FAIL drain_hold got %b exp 10", {o_blk[1], o_issue[1]}); end
        rst = 1; #1;
        checks++; if ({o_done[1], o_stall[1]} !== 33'd0) begin errors++; $display("FAIL drain_rst got done %b stall %0d exp 0 0", o_done[1], o_stall[1]); end
        rst = 0; #1;
        checks++; if ({o_blk[1], o_issue[1]} !== 2'b01) begin errors++; $display("FAIL drain_rst_run got %b exp 01", {o_blk[1], o_issue[1]}); end
        nxt();
    endtask

    // Reference: per-register outstanding-writer counts, drain phase and stall tally per mode.
    int     pend [2][32];
    int     phase [2];   // 0 running, 1 draining, 2 drain just completed
    longint mstall [2];

    task automatic test_random();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            phase[d] = 0; mstall[d] = 0;
            for (int r = 0; r < 32; r++) pend[d][r] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            int  off, w, k;
            logic eissue [2];
            idle();
            id_valid = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NSRC; i++) id_rs_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
            id_rs_used = NSRC'($urandom);
            id_rd_addr = AW'($urandom_range(0, 7));
            id_rd_wen  = ($urandom_range(0, 2) != 0);
            ls_mem_busy = ($urandom_range(0, 3) == 0);
            ls_done     = ls_mem_busy && ($urandom_range(0, 1) == 1);
            w = 0; off = $urandom_range(0, 6);
            for (int j = 0; j < 7; j++) begin
                int r = 1 + (off + j) % 7;
                if (w == 0 && pend[0][r] > 0 && pend[1][r] > 0) w = r;
            end
            if (w != 0 && $urandom_range(0, 9) < 6) retire(w);
            else if ($urandom_range(0, 4) == 0) begin wb_valid = 1; wb_wen = 0; wb_rd = AW'($urandom_range(0, 7)); end
            redirect_valid = ($urandom_range(0, 7) == 0);
            k = 0; off = $urandom_range(0, 6);
            for (int j = 0; j < 7; j++) begin
                int r = 1 + (off + j) % 7;
                int hit = (wb_valid && wb_wen && wb_rd == AW'(r)) ? 1 : 0;
                if (k == 0 && pend[0][r] - hit >= 1 && pend[1][r] - hit >= 1) k = r;
            end
            if (redirect_valid && k != 0 && $urandom_range(0, 1) == 1) begin
                kill_valid = 1; kill_wen = 1; kill_rd = AW'(k);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                logic blk, exen, iden, ifen;
                logic [NSRC-1:0] byp;
                blk = 0; byp = '0;
                for (int i = 0; i < NSRC; i++) begin
                    int rs = int'(id_rs_addr[i*AW +: AW]);
                    int retiring = (wb_valid && wb_wen && int'(wb_rd) == rs) ? 1 : 0;
                    if (id_rs_used[i] && rs != 0) begin
                        if (d == 1) begin
                            if (pend[d][rs] - retiring > 0) blk = 1;
                            else if (retiring == 1) byp[i] = 1;
                        end else if (pend[d][rs] > 0) blk = 1;
                    end
                end
                if (id_rd_wen && id_rd_addr != 0 && pend[d][id_rd_addr] >= MAXP) blk = 1;
                exen = !(ls_mem_busy && !ls_done);
                eissue[d] = id_valid && !blk && exen && !redirect_valid && phase[d] == 0;
                iden = eissue[d] || (!id_valid && phase[d] == 0);
                ifen = iden || !id_valid;
                checks++; if ({o_blk[d], o_byp[d], o_issue[d]} !== {blk, byp, eissue[d]})
                    begin errors++; $display("FAIL rand_hazard c%0d d%0d got %b exp %b", c, d, {o_blk[d], o_byp[d], o_issue[d]}, {blk, byp, eissue[d]}); end
                checks++; if ({o_ifen[d], o_iden[d], o_exen[d], o_iff[d], o_idf[d]} !== {ifen, iden, exen, redirect_valid, redirect_valid})
                    begin errors++; $display("FAIL rand_ctrl c%0d d%0d got %b exp %b", c, d, {o_ifen[d], o_iden[d], o_exen[d], o_iff[d], o_idf[d]}, {ifen, iden, exen, redirect_valid, redirect_valid}); end
                checks++; if (o_stall[d] !== 32'(mstall[d]) || o_done[d] !== (phase[d] == 2))
                    begin errors++; $display("FAIL rand_regs c%0d d%0d got stall %0d done %b exp %0d %b", c, d, o_stall[d], o_done[d], mstall[d], phase[d] == 2); end
            end
            for (int d = 0; d < 2; d++) begin
                int busy_regs = 0;
                for (int r = 1; r < 32; r++) if (pend[d][r] != 0) busy_regs++;
                if (phase[d] == 0) phase[d] = drain_req ? 1 : 0;
                else if (phase[d] == 1) phase[d] = (busy_regs == 0 && !ls_mem_busy) ? 2 : 1;
                else phase[d] = 0;
                if (id_valid && !eissue[d] && mstall[d] < 64'hFFFF_FFFF) mstall[d]++;
                if (eissue[d] && id_rd_wen && id_rd_addr != 0) pend[d][id_rd_addr]++;
                if (wb_valid && wb_wen && wb_rd != 0) pend[d][wb_rd]--;
                if (kill_valid && kill_wen && kill_rd != 0) pend[d][kill_rd]--;
            end
            nxt();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_raw_bypass();
        test_overflow();
        test_kill();
        test_mem_wait();
        test_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
